low_freq_measure_controller: RTL and testbench

LOW_FREQ_MEASURE_CONTROLLER -- requirements
Module: low_freq_measure_controller

---
 rtl/low_freq_measure_controller.sv | 103 ++++++++++
 tb/tb_low_freq_measure_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/low_freq_measure_controller.sv
// low_freq_measure_controller: reciprocal low-frequency meter driving an external divider and bin-to-BCD converter
module low_freq_measure_controller #(
  parameter int TICK_CYCLES = 100,
  parameter int TIMEOUT_US = 2_000_000,
  parameter int PERIOD_W = 22,
  parameter logic [31:0] DIVIDEND = 32'd1_000_000_000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                si_i,
  output logic                div_start_o,
  output logic [31:0]         dividend_o,
  output logic [PERIOD_W-1:0] divisor_o,
  input  logic                div_done_i,
  input  logic [31:0]         quotient_i,
  output logic                bcd_start_o,
  output logic [31:0]         bcd_bin_o,
  input  logic                bcd_done_i,
  input  logic [39:0]         bcd_i,
  output logic [15:0]         disp_o,
  output logic [3:0]          dp_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_US + 1);
  typedef enum logic [3:0] {IDLE, WAIT_E1, MEASURE, DIV_REQ, DIV_WAIT, BCD_REQ, BCD_WAIT, SCALE, DONE} state_t;
  state_t state, state_nxt;
  logic s1, s2, s3, rise, tick, counting, timed_out;
  logic [PW-1:0] pre;
  logic [TW-1:0] tmo;
  logic [PERIOD_W-1:0] per, per_inc, per_q;
  logic [31:0] quo;
  logic [39:0] bcd;
  logic [3:0] k, w, dp_nxt;
  logic [15:0] disp_nxt;
  assign rise = s2 & ~s3;
  assign tick = pre == PW'(TICK_CYCLES - 1);
  assign counting = state == WAIT_E1 || state == MEASURE;
  assign timed_out = tmo == TW'(TIMEOUT_US);
  // the tick landing on the edge cycle still counts, so an exact N us period latches N
  assign per_inc = (tick && !(&per)) ? per + 1'b1 : per;
  assign div_start_o = state == DIV_REQ;
  assign dividend_o = DIVIDEND;
  assign divisor_o = per_q;
  assign bcd_start_o = state == BCD_REQ;
  assign bcd_bin_o = quo;
  assign done_o = state == DONE;
  assign busy_o = state != IDLE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = start_i ? WAIT_E1 : IDLE;
      WAIT_E1:  state_nxt = rise ? MEASURE : timed_out ? IDLE : WAIT_E1;
      MEASURE:  state_nxt = rise ? (per_inc == '0 ? IDLE : DIV_REQ) : timed_out ? IDLE : MEASURE;
      DIV_REQ:  state_nxt = DIV_WAIT;
      DIV_WAIT: state_nxt = div_done_i ? BCD_REQ : DIV_WAIT;
      BCD_REQ:  state_nxt = BCD_WAIT;
      BCD_WAIT: state_nxt = bcd_done_i ? SCALE : BCD_WAIT;
      SCALE:    state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end
  always_comb begin
    k = 4'd0;
    for (int i = 1; i < 10; i++) if (bcd[4*i +: 4] != 4'd0) k = 4'(i);
    w = k < 4'd3 ? 4'd3 : k;
    disp_nxt = bcd[{w - 4'd3, 2'b00} +: 16];
    dp_nxt = w <= 4'd6 ? 4'(4'b0001 << (4'd6 - w)) : 4'b0000;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      {s3, s2, s1} <= 3'b000;
      pre <= '0;
      tmo <= '0;
      per <= '0;
      per_q <= '0;
      quo <= '0;
      bcd <= '0;
      disp_o <= 16'h0000;
      dp_o <= 4'b0000;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      {s3, s2, s1} <= {s2, s1, si_i};
      pre <= (!counting || state_nxt != state || tick) ? '0 : pre + 1'b1;
      tmo <= (!counting || state_nxt != state) ? '0 : tick ? tmo + 1'b1 : tmo;
      per <= state == MEASURE ? per_inc : '0;
      if (state == MEASURE && rise) per_q <= per_inc;
      if (state == DIV_WAIT && div_done_i) quo <= quotient_i;
      if (state == BCD_WAIT && bcd_done_i) bcd <= bcd_i;
      if (state == SCALE) begin
        disp_o <= disp_nxt;
        dp_o <= dp_nxt;
      end
      err_o <= (state == IDLE && start_i) ? 1'b0 : (counting && state_nxt == IDLE) ? 1'b1 : err_o;
    end
  end
endmodule

// File: tb/tb_low_freq_measure_controller.sv
// tb_low_freq_measure_controller: randomized period stimulus with scoreboard checking of displayed results
module tb_low_freq_measure_controller;
  localparam int T = 4;
  localparam int TO = 1200;
  localparam int PW = 10;
  localparam logic [31:0] DIVIDEND = 32'd1_000_000_000;
  typedef struct {bit is_err; logic [15:0] disp; logic [3:0] dp;} exp_t;
  logic clk = 0, reset = 1, start = 0, si = 0;
  logic div_start, div_done, bcd_start, bcd_done, done, busy, err;
  logic [31:0] dividend, quotient, bcd_bin;
  logic [PW-1:0] divisor;
  logic [39:0] bcd;
  logic [15:0] disp;
  logic [3:0] dp;
  logic div_done_r = 0, bcd_done_r = 0, stray_div = 0, stray_bcd = 0, hold_div = 0, err_d = 0;
  logic [31:0] q_r = 0;
  logic [39:0] bcd_r = 0;
  logic [15:0] m_disp = 0;
  logic [3:0] m_dp = 0;
  exp_t sb[$];
  logic [PW-1:0] div_q[$];
  exp_t e;
  int vectors = 0, miscompares = 0, n_divs = 0;
  assign div_done = div_done_r | stray_div;
  assign quotient = stray_div ? 32'hDEADBEEF : q_r;
  assign bcd_done = bcd_done_r | stray_bcd;
  assign bcd = stray_bcd ? 40'h99_9999_9999 : bcd_r;
  always #5 clk = ~clk;
  low_freq_measure_controller #(.TICK_CYCLES(T), .TIMEOUT_US(TO), .PERIOD_W(PW), .DIVIDEND(DIVIDEND)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .si_i(si),
    .div_start_o(div_start), .dividend_o(dividend), .divisor_o(divisor),
    .div_done_i(div_done), .quotient_i(quotient),
    .bcd_start_o(bcd_start), .bcd_bin_o(bcd_bin), .bcd_done_i(bcd_done), .bcd_i(bcd),
    .disp_o(disp), .dp_o(dp), .busy_o(busy), .done_o(done), .err_o(err)
  );
  // reference: period in whole us, frequency in mHz, leading four significant digits with decimal point
  function automatic void push_expect(input int p);
    longint per, q;
    int d[10];
    int k, w;
    exp_t x;
    per = p / T;
    if (per > 2**PW - 1) per = 2**PW - 1;
    x.is_err = per == 0;
    x.disp = m_disp;
    x.dp = m_dp;
    if (!x.is_err) begin
      q = DIVIDEND / per;
      k = 0;
      for (int i = 0; i < 10; i++) begin
        d[i] = int'(q % 10);
        q = q / 10;
        if (d[i] != 0) k = i;
      end
      w = k < 3 ? 3 : k;
      x.disp = {4'(d[w]), 4'(d[w-1]), 4'(d[w-2]), 4'(d[w-3])};
      x.dp = w <= 6 ? 4'(1 << (6 - w)) : 4'd0;
      div_q.push_back(PW'(per));
      m_disp = x.disp;
      m_dp = x.dp;
    end
    sb.push_back(x);
  endfunction
  always @(negedge clk) begin
    if (reset) n_divs = 0;
    else begin
      if (div_start) n_divs++;
      if (done || (err && !err_d)) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL result: unexpected done=%0b err=%0b disp=%h dp=%b", done, err, disp, dp);
        end else begin
          e = sb.pop_front();
          if (done == e.is_err || err != e.is_err || disp != e.disp || dp != e.dp || n_divs != (e.is_err ? 0 : 1)) begin
            miscompares++;
            $display("FAIL result: got done=%0b err=%0b disp=%h dp=%b divs=%0d, want err=%0b disp=%h dp=%b divs=%0d",
                     done, err, disp, dp, n_divs, e.is_err, e.disp, e.dp, e.is_err ? 0 : 1);
          end
        end
        n_divs = 0;
      end
    end
    err_d = err;
  end
  initial begin
    logic [PW-1:0] xd;
    longint v;
    forever begin
      @(negedge clk);
      if (div_start && !reset) begin
        vectors++;
        if (div_q.size() == 0) begin
          miscompares++;
          $display("FAIL divisor: unexpected div_start_o with divisor %0d", divisor);
        end else begin
          xd = div_q.pop_front();
          if (divisor !== xd || dividend !== DIVIDEND) begin
            miscompares++;
            $display("FAIL divisor: got %0d/%0d, want %0d/%0d", dividend, divisor, DIVIDEND, xd);
          end
        end
        if (!hold_div) begin
          v = divisor == 0 ? 0 : DIVIDEND / divisor;
          repeat ($urandom_range(1, 5)) @(posedge clk);
          #1 q_r = 32'(v);
          div_done_r = 1;
          @(posedge clk);
          #1 div_done_r = 0;
        end
      end
      if (bcd_start && !reset) begin
        v = bcd_bin;
        for (int i = 0; i < 10; i++) begin
          bcd_r[4*i +: 4] = 4'(v % 10);
          v = v / 10;
        end
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 bcd_done_r = 1;
        @(posedge clk);
        #1 bcd_done_r = 0;
      end
    end
  end
  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (busy && n < bound) begin
      @(posedge clk);
      #1 n++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle: busy_o still %0b after %0d cycles, want 0", busy, bound);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic drive(input int p, input bit restart, input bit stray);
    int h, l;
    si = 0;
    repeat (6) @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    if (stray) begin
      stray_div = 1;
      stray_bcd = 1;
      @(posedge clk);
      #1 stray_div = 0;
      stray_bcd = 0;
    end
    repeat ($urandom_range(3, 12)) @(posedge clk);
    #1 si = 1;
    h = p / 2;
    l = p - h;
    repeat (h) @(posedge clk);
    #1 si = 0;
    if (restart && l >= 2) begin
      start = 1;
      @(posedge clk);
      #1 start = 0;
      l--;
    end
    repeat (l) @(posedge clk);
    #1 si = 1;
  endtask
  task automatic measure(input int p, input bit restart, input bit stray);
    int n;
    push_expect(p);
    drive(p, restart, stray);
    wait_idle(p + 200, n);
  endtask
  initial begin
    int n;
    bit seen;
    exp_t x;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    vectors++;
    if (busy || err || done || div_start || bcd_start || disp != 16'h0 || dp != 4'h0) begin
      miscompares++;
      $display("FAIL reset: busy=%0b err=%0b done=%0b ds=%0b bs=%0b disp=%h dp=%b, want all 0",
               busy, err, done, div_start, bcd_start, disp, dp);
    end
    measure(4000, 0, 0);
    measure(1600, 1, 1);
    measure(4400, 0, 0);
    measure(4, 0, 1);
    measure(3, 0, 0);
    measure(2, 1, 0);
    x.is_err = 1;
    x.disp = m_disp;
    x.dp = m_dp;
    sb.push_back(x);
    si = 0;
    repeat (6) @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_idle(TO * T + 400, n);
    vectors++;
    if (n < TO * T - 2 || n > TO * T + 4 || !err) begin
      miscompares++;
      $display("FAIL timeout: took %0d cycles err=%0b, want about %0d err=1", n, err, TO * T);
    end
    hold_div = 1;
    div_q.push_back(PW'(100));
    drive(400, 0, 0);
    n = 0;
    while (!div_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    m_disp = 0;
    m_dp = 0;
    @(negedge clk);
    vectors++;
    if (n >= 200 || busy || err || done || div_start || bcd_start || disp != 16'h0 || dp != 4'h0) begin
      miscompares++;
      $display("FAIL abort_reset: waited=%0d busy=%0b err=%0b disp=%h dp=%b, want busy=0 err=0 disp=0000 dp=0000",
               n, busy, err, disp, dp);
    end
    @(posedge clk);
    #1 stray_div = 1;
    @(posedge clk);
    #1 stray_div = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= busy | bcd_start | done;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL late_done: activity=%0b after reset, want 0", seen);
    end
    hold_div = 0;
    for (int i = 0; i < 14; i++) measure($urandom_range(2, 1600), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (20) @(posedge clk);
    vectors++;
    if (sb.size() != 0 || div_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results and %0d divisors outstanding, want 0", sb.size(), div_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
